fwd_track_unit: RTL and testbench
=================================

Name: fwd_track_unit

Overview:
- Producer-side counterpart to the D-stage stall logic in the P5 five-stage MIPS pipeline.
- Carries each writer instruction's destination register, Tnew and RegWrite flag through the E/M/W stage records.
- Decrements Tnew as the instruction advances and exports the E/M writer info that the stall logic consumes.
- Resolves forwarded operand values for D, E and M stage consumers.

Parameters:
- DW, 32, data width of operands and results
- AW, 5, register address width

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- id_ex_clr  in  1  stall bubble; E record loads empty instead of D info
- regwrite_D  in  1  D instruction writes the register file
- dest_D  in  AW  D destination register (rd/rt/31)
- tnew_D  in  2  Tnew at E entry (lw=2, add/sub/ori=1, lui/jal=0)
- wdata_E, wdata_M, wdata_W  in  DW each  result currently held in that stage
- rs_D, rt_D, rs_E, rt_E, rt_M  in  AW each  consumer register numbers
- rf_rs_D, rf_rt_D, val_rs_E, val_rt_E, val_rt_M  in  DW each  unforwarded operand values
- fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, fwd_rt_M  out  DW each  resolved operands
- Tnew_E, Tnew_M  out  2 each  current Tnew of E/M records
- Num_new_E, Num_new_M, Num_new_W  out  AW each  destination of E/M/W records
- Regwrite_E, Regwrite_M, Regwrite_W  out  1 each  record write-enable flags
- pending_err  out  1  sticky forwarding-ordering error (see Optional Feature)

Behaviour:
- Records E, M, W each hold {regwrite, dest, tnew}. All three update every rising edge; there is no enable.
- E record loads {regwrite_D, dest_D, tnew_D}. If id_ex_clr=1, it loads {0, 0, 0} instead.
- M record loads E's contents with tnew = max(Tnew_E-1, 0).
- W record loads M's contents with tnew forced to 0.
- Reset: all records {0, 0, 0}, so all Tnew/Num/Regwrite outputs are 0 and pending_err=0. Reset wins over id_ex_clr.
- A record whose dest=0 is stored as-is but never matches; $0 is never forwarded.
- A record is a live writer when regwrite=1, dest!=0 and dest equals the consumer register.
- A record is ready when tnew==0.
- D consumers search E, then M, then W. E consumers search M, then W. M consumers search W only.
- Forwarding rule, applied to the first live writer found:
  - If it is ready, output that stage's wdata.
  - If it is not ready, output the unforwarded value; this is the "pending" case.
  - If no live writer exists, output the unforwarded value.
- The first live writer is always the youngest, so it always wins, even when it is not ready. An older ready writer must never be chosen over it.
- All forwarding outputs are purely combinational from the current records and inputs; latency 0.
- Tnew/Num/Regwrite outputs are registered; they change only at clock edges.
- Simultaneous id_ex_clr with a writer in D: the D info is dropped. The same instruction is re-presented next cycle because D is held.
- Tnew saturates at 0 and never wraps.

Optional Feature:
- Macro FWD_PENDING_CHECK_EN.
- Defined: pending_err sets on any cycle a consumer hits the pending case at its point of use, i.e. any D consumer, or an E/M consumer whose stage uses the operand that cycle. In this block that means every E/M consumer port each cycle. pending_err stays 1 until reset.
- Not defined: pending_err tied 0 and no check logic is synthesised.

Test Plan:
- Reset: assert reset 2 cycles with D writer present -> all records 0, Tnew_E=Tnew_M=0, pending_err=0.
- ALU chain: D addu $8 (tnew_D=1) at cycle 0; cycle 1 Tnew_E=1, Num_new_E=8; cycle 2 Tnew_M=0, rs_E=8, wdata_M=0x1234 -> fwd_rs_E=0x1234.
- lw then stall: lw $9 (tnew_D=2), id_ex_clr=1 next cycle -> E record {0,0,0}; M record Tnew_M=1, Num_new_M=9; following cycle W holds 9, rt_D=9, wdata_W=0xCAFE -> fwd_rt_D=0xCAFE.
- Priority: E writes $5 ready (jal-like, wdata_E=0xA), M writes $5 ready (wdata_M=0xB), rs_D=5 -> fwd_rs_D=0xA; E not ready (tnew=1) -> fwd_rs_D=rf_rs_D, not 0xB.
- $0 immunity: writer with dest=0, regwrite=1, rs_D=0, rf_rs_D=0 -> fwd_rs_D=0 regardless of wdata.
- FWD_PENDING_CHECK_EN: lw $4 in E (Tnew_E=2), rs_D=4, no stall applied -> pending_err=1 next cycle and stays 1 until reset; without macro stays 0.

Source files
------------

// File: rtl/fwd_track_unit.sv
// rtl/fwd_track_unit.sv - E/M/W writer tracking (dest, Tnew, RegWrite) and operand forwarding
// Optional macro FWD_PENDING_CHECK_EN: enables the sticky pending_err check.
module fwd_track_unit #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          id_ex_clr,
  input  logic          regwrite_D,
  input  logic [AW-1:0] dest_D,
  input  logic [1:0]    tnew_D,
  input  logic [DW-1:0] wdata_E,
  input  logic [DW-1:0] wdata_M,
  input  logic [DW-1:0] wdata_W,
  input  logic [AW-1:0] rs_D,
  input  logic [AW-1:0] rt_D,
  input  logic [AW-1:0] rs_E,
  input  logic [AW-1:0] rt_E,
  input  logic [AW-1:0] rt_M,
  input  logic [DW-1:0] rf_rs_D,
  input  logic [DW-1:0] rf_rt_D,
  input  logic [DW-1:0] val_rs_E,
  input  logic [DW-1:0] val_rt_E,
  input  logic [DW-1:0] val_rt_M,
  output logic [DW-1:0] fwd_rs_D,
  output logic [DW-1:0] fwd_rt_D,
  output logic [DW-1:0] fwd_rs_E,
  output logic [DW-1:0] fwd_rt_E,
  output logic [DW-1:0] fwd_rt_M,
  output logic [1:0]    Tnew_E,
  output logic [1:0]    Tnew_M,
  output logic [AW-1:0] Num_new_E,
  output logic [AW-1:0] Num_new_M,
  output logic [AW-1:0] Num_new_W,
  output logic          Regwrite_E,
  output logic          Regwrite_M,
  output logic          Regwrite_W,
  output logic          pending_err
);

  // Stage records. W has no Tnew register: a W writer is always ready.
  logic          regwrite_e_q, regwrite_e_d;
  logic [AW-1:0] dest_e_q, dest_e_d;
  logic [1:0]    tnew_e_q, tnew_e_d;
  logic          regwrite_m_q, regwrite_m_d;
  logic [AW-1:0] dest_m_q, dest_m_d;
  logic [1:0]    tnew_m_q, tnew_m_d;
  logic          regwrite_w_q, regwrite_w_d;
  logic [AW-1:0] dest_w_q, dest_w_d;

  logic rdy_e, rdy_m;

  // Per-consumer hit vectors, bit 0 = E, bit 1 = M, bit 2 = W.
  logic [2:0] hit_rs_d, hit_rt_d, hit_rs_e, hit_rt_e, hit_rt_m;

  // A record is a live writer for register r when it writes, is not $0 and matches.
  function automatic logic live(input logic rw, input logic [AW-1:0] dst,
                                input logic [AW-1:0] r);
    return rw && (dst != '0) && (dst == r);
  endfunction

  // Youngest live writer wins; if it is not ready the unforwarded value is kept.
  function automatic logic [DW-1:0] fwd_val(input logic [2:0] hit,
                                            input logic rdy_e_i, input logic rdy_m_i,
                                            input logic [DW-1:0] d_e, input logic [DW-1:0] d_m,
                                            input logic [DW-1:0] d_w, input logic [DW-1:0] fb);
    if (hit[0])      return rdy_e_i ? d_e : fb;
    else if (hit[1]) return rdy_m_i ? d_m : fb;
    else if (hit[2]) return d_w;
    else             return fb;
  endfunction

  // Next-state of the E/M/W records; Tnew decrements with saturation at 0.
  always_comb begin
    regwrite_e_d = id_ex_clr ? 1'b0 : regwrite_D;
    dest_e_d     = id_ex_clr ? '0   : dest_D;
    tnew_e_d     = id_ex_clr ? 2'd0 : tnew_D;
    regwrite_m_d = regwrite_e_q;
    dest_m_d     = dest_e_q;
    tnew_m_d     = (tnew_e_q == 2'd0) ? 2'd0 : tnew_e_q - 2'd1;
    regwrite_w_d = regwrite_m_q;
    dest_w_d     = dest_m_q;
  end

  // Record registers; reset takes priority over the stall bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      regwrite_e_q <= 1'b0;
      dest_e_q     <= '0;
      tnew_e_q     <= 2'd0;
      regwrite_m_q <= 1'b0;
      dest_m_q     <= '0;
      tnew_m_q     <= 2'd0;
      regwrite_w_q <= 1'b0;
      dest_w_q     <= '0;
    end else begin
      regwrite_e_q <= regwrite_e_d;
      dest_e_q     <= dest_e_d;
      tnew_e_q     <= tnew_e_d;
      regwrite_m_q <= regwrite_m_d;
      dest_m_q     <= dest_m_d;
      tnew_m_q     <= tnew_m_d;
      regwrite_w_q <= regwrite_w_d;
      dest_w_q     <= dest_w_d;
    end
  end

  assign rdy_e = (tnew_e_q == 2'd0);
  assign rdy_m = (tnew_m_q == 2'd0);

  // D consumers search E, M, W; E consumers search M, W; M consumers search W.
  assign hit_rs_d = {live(regwrite_w_q, dest_w_q, rs_D), live(regwrite_m_q, dest_m_q, rs_D),
                     live(regwrite_e_q, dest_e_q, rs_D)};
  assign hit_rt_d = {live(regwrite_w_q, dest_w_q, rt_D), live(regwrite_m_q, dest_m_q, rt_D),
                     live(regwrite_e_q, dest_e_q, rt_D)};
  assign hit_rs_e = {live(regwrite_w_q, dest_w_q, rs_E), live(regwrite_m_q, dest_m_q, rs_E), 1'b0};
  assign hit_rt_e = {live(regwrite_w_q, dest_w_q, rt_E), live(regwrite_m_q, dest_m_q, rt_E), 1'b0};
  assign hit_rt_m = {live(regwrite_w_q, dest_w_q, rt_M), 2'b00};

  assign fwd_rs_D = fwd_val(hit_rs_d, rdy_e, rdy_m, wdata_E, wdata_M, wdata_W, rf_rs_D);
  assign fwd_rt_D = fwd_val(hit_rt_d, rdy_e, rdy_m, wdata_E, wdata_M, wdata_W, rf_rt_D);
  assign fwd_rs_E = fwd_val(hit_rs_e, rdy_e, rdy_m, wdata_E, wdata_M, wdata_W, val_rs_E);
  assign fwd_rt_E = fwd_val(hit_rt_e, rdy_e, rdy_m, wdata_E, wdata_M, wdata_W, val_rt_E);
  assign fwd_rt_M = fwd_val(hit_rt_m, rdy_e, rdy_m, wdata_E, wdata_M, wdata_W, val_rt_M);

  assign Tnew_E     = tnew_e_q;
  assign Tnew_M     = tnew_m_q;
  assign Num_new_E  = dest_e_q;
  assign Num_new_M  = dest_m_q;
  assign Num_new_W  = dest_w_q;
  assign Regwrite_E = regwrite_e_q;
  assign Regwrite_M = regwrite_m_q;
  assign Regwrite_W = regwrite_w_q;

`ifdef FWD_PENDING_CHECK_EN
  logic pending_err_q, pending_err_d;
  logic pend_any;

  // Pending means the youngest live writer exists but has not produced its result.
  function automatic logic is_pending(input logic [2:0] hit, input logic rdy_e_i,
                                      input logic rdy_m_i);
    if (hit[0])      return !rdy_e_i;
    else if (hit[1]) return !rdy_m_i;
    else             return 1'b0;
  endfunction

  assign pend_any = is_pending(hit_rs_d, rdy_e, rdy_m) | is_pending(hit_rt_d, rdy_e, rdy_m) |
                    is_pending(hit_rs_e, rdy_e, rdy_m) | is_pending(hit_rt_e, rdy_e, rdy_m) |
                    is_pending(hit_rt_m, rdy_e, rdy_m);

  // Sticky error: once set it holds until reset.
  always_comb begin
    pending_err_d = pending_err_q | pend_any;
  end

  // Error flag register.
  always_ff @(posedge clk) begin
    if (reset) pending_err_q <= 1'b0;
    else       pending_err_q <= pending_err_d;
  end

  assign pending_err = pending_err_q;
`else
  assign pending_err = 1'b0;
`endif

endmodule

// File: tb/tb_fwd_track_unit.sv
// tb/tb_fwd_track_unit.sv - scoreboard bench for fwd_track_unit against an instruction-history model
module tb_fwd_track_unit;

  logic        clk = 1'b0;
  logic        reset, id_ex_clr, regwrite_D;
  logic [4:0]  dest_D;
  logic [1:0]  tnew_D;
  logic [31:0] wdata_E, wdata_M, wdata_W;
  logic [4:0]  rs_D, rt_D, rs_E, rt_E, rt_M;
  logic [31:0] rf_rs_D, rf_rt_D, val_rs_E, val_rt_E, val_rt_M;
  logic [31:0] fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, fwd_rt_M;
  logic [1:0]  Tnew_E, Tnew_M;
  logic [4:0]  Num_new_E, Num_new_M, Num_new_W;
  logic        Regwrite_E, Regwrite_M, Regwrite_W, pending_err;

  fwd_track_unit #(.DW(32), .AW(5)) dut (
    .clk(clk), .reset(reset), .id_ex_clr(id_ex_clr), .regwrite_D(regwrite_D),
    .dest_D(dest_D), .tnew_D(tnew_D),
    .wdata_E(wdata_E), .wdata_M(wdata_M), .wdata_W(wdata_W),
    .rs_D(rs_D), .rt_D(rt_D), .rs_E(rs_E), .rt_E(rt_E), .rt_M(rt_M),
    .rf_rs_D(rf_rs_D), .rf_rt_D(rf_rt_D), .val_rs_E(val_rs_E), .val_rt_E(val_rt_E),
    .val_rt_M(val_rt_M),
    .fwd_rs_D(fwd_rs_D), .fwd_rt_D(fwd_rt_D), .fwd_rs_E(fwd_rs_E), .fwd_rt_E(fwd_rt_E),
    .fwd_rt_M(fwd_rt_M),
    .Tnew_E(Tnew_E), .Tnew_M(Tnew_M),
    .Num_new_E(Num_new_E), .Num_new_M(Num_new_M), .Num_new_W(Num_new_W),
    .Regwrite_E(Regwrite_E), .Regwrite_M(Regwrite_M), .Regwrite_W(Regwrite_W),
    .pending_err(pending_err)
  );

  always #5 clk = ~clk;

  // Model: the instructions sitting in E, M, W with the Tnew they had on entering E.
  typedef struct packed {
    logic       rw;
    logic [4:0] dest;
    logic [1:0] t0;
  } instr_t;

  typedef struct packed {
    logic [4:0][31:0] f;
    logic [1:0]       te;
    logic [1:0]       tm;
    logic [2:0][4:0]  n;
    logic [2:0]       r;
    logic             pe;
  } exp_t;

  instr_t stg [3];
  logic   model_pend = 1'b0;
  logic   pend_now   = 1'b0;
  exp_t   exp_q [$];
  int     errors = 0;
  int     checks = 0;

  // Tnew after spending s cycles past E entry; a W writer is always done.
  function automatic logic [1:0] tnew_at(input int s);
    logic [1:0] t;
    t = stg[s].t0;
    if (s == 2) return 2'd0;
    if (s == 1) return (t == 2'd0) ? 2'd0 : t - 2'd1;
    return t;
  endfunction

  function automatic logic [31:0] model_fwd(input int first, input logic [4:0] r,
                                           input logic [31:0] fb, output logic pend);
    logic [31:0] wd [3];
    wd[0] = wdata_E; wd[1] = wdata_M; wd[2] = wdata_W;
    for (int s = first; s < 3; s++) begin
      if (stg[s].rw && stg[s].dest != 5'd0 && stg[s].dest == r) begin
        pend = (tnew_at(s) != 2'd0);
        return pend ? fb : wd[s];
      end
    end
    pend = 1'b0;
    return fb;
  endfunction

  task automatic push_exp();
    exp_t e;
    logic p, pn;
    pn = 1'b0;
    e.f[0] = model_fwd(0, rs_D, rf_rs_D, p);  pn = pn | p;
    e.f[1] = model_fwd(0, rt_D, rf_rt_D, p);  pn = pn | p;
    e.f[2] = model_fwd(1, rs_E, val_rs_E, p); pn = pn | p;
    e.f[3] = model_fwd(1, rt_E, val_rt_E, p); pn = pn | p;
    e.f[4] = model_fwd(2, rt_M, val_rt_M, p); pn = pn | p;
    e.te = tnew_at(0);
    e.tm = tnew_at(1);
    for (int i = 0; i < 3; i++) begin
      e.n[i] = stg[i].dest;
      e.r[i] = stg[i].rw;
    end
`ifdef FWD_PENDING_CHECK_EN
    e.pe = model_pend;
`else
    e.pe = 1'b0;
`endif
    pend_now = pn;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 3; i++) stg[i] = '0;
      model_pend = 1'b0;
    end else begin
      model_pend = model_pend | pend_now;
      stg[2] = stg[1];
      stg[1] = stg[0];
      stg[0] = id_ex_clr ? instr_t'(0) : instr_t'({regwrite_D, dest_D, tnew_D});
    end
    pend_now = 1'b0;
    #1;
  endtask

  task automatic cyc();
    push_exp();
    tick();
  endtask

  task automatic idle();
    reset = 1'b0; id_ex_clr = 1'b0; regwrite_D = 1'b0; dest_D = 5'd0; tnew_D = 2'd0;
    wdata_E = 32'h0; wdata_M = 32'h0; wdata_W = 32'h0;
    rs_D = 5'd0; rt_D = 5'd0; rs_E = 5'd0; rt_E = 5'd0; rt_M = 5'd0;
    rf_rs_D = 32'h0; rf_rt_D = 32'h0; val_rs_E = 32'h0; val_rt_E = 32'h0; val_rt_M = 32'h0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares whatever the DUT presents against the oldest queued expectation.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("fwd_rs_D", fwd_rs_D, e.f[0]);
      chk("fwd_rt_D", fwd_rt_D, e.f[1]);
      chk("fwd_rs_E", fwd_rs_E, e.f[2]);
      chk("fwd_rt_E", fwd_rt_E, e.f[3]);
      chk("fwd_rt_M", fwd_rt_M, e.f[4]);
      chk("Tnew_E", 32'(Tnew_E), 32'(e.te));
      chk("Tnew_M", 32'(Tnew_M), 32'(e.tm));
      chk("Num_new_E", 32'(Num_new_E), 32'(e.n[0]));
      chk("Num_new_M", 32'(Num_new_M), 32'(e.n[1]));
      chk("Num_new_W", 32'(Num_new_W), 32'(e.n[2]));
      chk("Regwrite_E", 32'(Regwrite_E), 32'(e.r[0]));
      chk("Regwrite_M", 32'(Regwrite_M), 32'(e.r[1]));
      chk("Regwrite_W", 32'(Regwrite_W), 32'(e.r[2]));
      chk("pending_err", 32'(pending_err), 32'(e.pe));
    end
  end

  initial begin
    for (int i = 0; i < 3; i++) stg[i] = '0;
    idle();
    // Reset for two cycles with a writer sitting in D.
    reset = 1'b1; regwrite_D = 1'b1; dest_D = 5'd8; tnew_D = 2'd1;
    tick();
    cyc();
    // ALU chain: addu $8 then consume in E from M.
    idle(); regwrite_D = 1'b1; dest_D = 5'd8; tnew_D = 2'd1; cyc();
    idle(); cyc();
    rs_E = 5'd8; wdata_M = 32'h1234; cyc();
    // lw $9 followed by a stall bubble, then consume from W in D.
    idle(); regwrite_D = 1'b1; dest_D = 5'd9; tnew_D = 2'd2; cyc();
    id_ex_clr = 1'b1; cyc();
    idle(); cyc();
    rt_D = 5'd9; wdata_W = 32'hCAFE; cyc();
    // Priority: two ready $5 writers in E and M.
    idle(); regwrite_D = 1'b1; dest_D = 5'd5; tnew_D = 2'd0; cyc(); cyc();
    idle(); rs_D = 5'd5; wdata_E = 32'hA; wdata_M = 32'hB; rf_rs_D = 32'h77; cyc();
    // Priority: E writer not ready must block an older ready M writer.
    idle(); regwrite_D = 1'b1; dest_D = 5'd5; tnew_D = 2'd0; cyc();
    tnew_D = 2'd1; cyc();
    idle(); rs_D = 5'd5; wdata_E = 32'hA; wdata_M = 32'hB; rf_rs_D = 32'h77; cyc();
    // $0 immunity.
    idle(); reset = 1'b1; cyc();
    idle(); regwrite_D = 1'b1; dest_D = 5'd0; tnew_D = 2'd0; cyc();
    idle(); rs_D = 5'd0; rf_rs_D = 32'h0; wdata_E = 32'hFFFF_FFFF; wdata_M = 32'h1; cyc();
    // Pending case: lw $4 in E read by D without a stall; flag must stick.
    idle(); reset = 1'b1; cyc();
    idle(); regwrite_D = 1'b1; dest_D = 5'd4; tnew_D = 2'd2; cyc();
    idle(); rs_D = 5'd4; rf_rs_D = 32'h44; wdata_E = 32'h99; cyc();
    idle(); repeat (4) cyc();
    // Randomized traffic over a small register set to provoke hazards.
    for (int i = 0; i < 3000; i++) begin
      reset      = ($urandom_range(0, 99) == 0);
      id_ex_clr  = ($urandom_range(0, 4) == 0);
      regwrite_D = 1'($urandom_range(0, 1));
      dest_D     = 5'($urandom_range(0, 3));
      tnew_D     = 2'($urandom_range(0, 2));
      wdata_E = $urandom; wdata_M = $urandom; wdata_W = $urandom;
      rs_D = 5'($urandom_range(0, 3)); rt_D = 5'($urandom_range(0, 3));
      rs_E = 5'($urandom_range(0, 3)); rt_E = 5'($urandom_range(0, 3));
      rt_M = 5'($urandom_range(0, 3));
      rf_rs_D = $urandom; rf_rt_D = $urandom;
      val_rs_E = $urandom; val_rt_E = $urandom; val_rt_M = $urandom;
      cyc();
    end
    idle();
    for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d expected=0 pending expectations", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
